bus_master_interface: RTL and testbench
=======================================

// Module: bus_master_interface
// PURPOSE
//  Single-master initiator for the shared system bus (addr/data/rd/wr/mask/fc).
//  Takes one request at a time from a core-side valid/ready port and runs one bus read or write.
//  Returns one response pulse per request.
//  Sits between a CPU/DMA front-end and the memory-mapped device responders.
// PARAMETERS
//  TIMEOUT_CYCLES  255  bus cycles to wait for fc_bus before abort (used only with timeout macro)
// PORTS
//  clk            in    1   system clock, all logic on posedge
//  rst_n          in    1   asynchronous, active-low reset
//  req_valid      in    1   request present
//  req_ready      out   1   block can accept a request (high only in IDLE)
//  req_write      in    1   1 = write, 0 = read
//  req_addr       in    32  byte address, passed to bus unchanged
//  req_wdata      in    32  write data, low-aligned (byte 0 in [7:0])
//  req_mask       in    4   byte-enable mask, low-aligned, passed unchanged
//  rsp_valid      out   1   one-cycle response pulse, no backpressure
//  rsp_rdata      out   32  read data; 0 for writes and errors
//  rsp_err        out   1   transaction aborted by timeout
//  addr_bus       out   32  bus address
//  data_bus       inout 32  driven only in WRITE, else 'z
//  rd_bus         out   1   bus read strobe
//  wr_bus         out   1   bus write strobe
//  data_mask_bus  out   4   bus byte mask
//  fc_bus         in    1   responder completion; 'z/0 = not complete, only ===1 counts
// BEHAVIOUR
//  Reset (rst_n=0, takes effect immediately):
//   - state=IDLE, req_ready=1
//   - rd_bus=wr_bus=0, data_mask_bus=0, addr_bus=0, data_bus='z
//   - rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0
//  States:
//   - IDLE: req_ready=1. On req_valid at an edge, latch addr/wdata/mask.
//     Go to WRITE if req_write=1, else to READ.
//   - READ: rd_bus=1, addr/mask driven. At the edge where fc_bus===1: capture data_bus into
//     rsp_rdata, pulse rsp_valid in the next cycle, go to IDLE.
//   - WRITE: wr_bus=1, data_bus=wdata. At the edge where fc_bus===1: go to RELEASE, pulse
//     rsp_valid (rdata=0) in RELEASE.
//   - RELEASE: rd=wr=0, addr held, data_bus='z. Minimum one cycle.
//     Exit to IDLE at the first edge where fc_bus!==1. This lets the responder leave its
//     done state, so back-to-back writes never see a stale fc.
//  Timing (edge 0 = acceptance):
//   - read: rd_bus high from cycle 1; with a combinational responder, rsp_valid in cycle 2.
//     req_ready is also 1 in cycle 2, so a new request can be accepted at edge 2.
//   - write: wr_bus high in cycles 1-2 with a one-cycle responder; rsp_valid in cycle 3;
//     req_ready returns in cycle 4.
//  Boundaries:
//   - addr_bus holds its last value in IDLE.
//   - mask=0 still runs a full transaction.
//   - req_valid outside IDLE is ignored.
//   - fc_bus===1 already in cycle 1 of READ completes in that cycle.
//   - Async reset mid-transaction drops strobes and releases data_bus immediately.
//     No rsp_valid is issued for the aborted request.
// CONFIGURATION
//  BUS_MASTER_TIMEOUT_EN defined:
//   - Counter clears on entry to READ/WRITE/RELEASE and increments each cycle without completion.
//   - READ/WRITE: after TIMEOUT_CYCLES cycles without fc_bus===1, pulse rsp_valid with
//     rsp_err=1 and rsp_rdata=0. A READ goes to IDLE; a WRITE goes to RELEASE.
//   - RELEASE: forced to IDLE after TIMEOUT_CYCLES cycles (no second response).
//  BUS_MASTER_TIMEOUT_EN undefined:
//   - No counter; waits for fc_bus indefinitely.
//   - rsp_err is tied to 0.
// TESTING
//  1) rst_n=0 mid-sim -> rd/wr=0, data_bus='z, req_ready=1, rsp_valid=0 immediately.
//  2) Write 0x00000001 @0x00001004 mask 4'hF to LED-style responder at 0x1000
//     -> wr_bus high cycles 1-2, rsp_valid cycle 3 with err=0, responder register=0x00000001.
//  3) Read @0x00001004 after test 2 -> rd_bus cycle 1, rsp_valid cycle 2,
//     rsp_rdata=0x00000001, req_ready=1 in cycle 2.
//  4) Back-to-back writes 0x11 then 0x22 @0x00001004 -> second wr_bus only after fc_bus
//     seen !==1; responder ends at 0x00000022, two rsp_valid pulses, no stale completion.
//  5) Byte write 0xAB @0x00001005 mask 4'b0001 -> bus shows addr 0x00001005,
//     data 0x000000AB, mask 4'b0001.
//  6) TIMEOUT_EN, TIMEOUT_CYCLES=16, read @0x90000000 (no responder) -> rd_bus high
//     cycles 1-16, rsp_valid cycle 17 with err=1 and rdata=0. Without the macro, rd_bus
//     stays high indefinitely.
//  7) rst_n low in cycle 2 of a write -> wr_bus=0 and data_bus='z at once, no rsp_valid.

Source files
------------

// File: rtl/bus_master_interface.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : bus_master_interface                                             |
// | Brief   : single-master initiator, one bus read/write per core request.    |
// |           Optional abort-on-timeout enabled by BUS_MASTER_TIMEOUT_EN.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bus_master_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_mask,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] addr_bus,
  inout  wire  [31:0] data_bus,
  output logic        rd_bus,
  output logic        wr_bus,
  output logic [3:0]  data_mask_bus,
  input  logic        fc_bus
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_READ    = 2'd1;
  localparam logic [1:0] c_WRITE   = 2'd2;
  localparam logic [1:0] c_RELEASE = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_mask;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        w_accept;
  logic        w_rsp_fire;
  logic        w_rsp_err;
  logic        w_capture;
  logic        w_fc_done;
  logic        w_tmo_hit;

  // A floating fc_bus must never count as completion; every test below is
  // written so that an unknown value falls into the "not complete" branch.
  assign w_fc_done = (fc_bus == 1'b1);

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int unsigned c_CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_tmo_cnt;
  logic               r_rsp_err;

  assign w_tmo_hit = (r_tmo_cnt == c_TMO_LAST);
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_next != r_state)
        r_tmo_cnt <= '0;
      else if (r_state != c_IDLE)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_rsp_fire)
        r_rsp_err <= w_rsp_err;
    end
  end
`else
  logic w_unused_cfg;
  assign w_tmo_hit    = 1'b0;
  assign rsp_err      = 1'b0;
  assign w_unused_cfg = (TIMEOUT_CYCLES != 0) | w_rsp_err;
`endif

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_rsp_fire = 1'b0;
    w_rsp_err  = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = req_write ? c_WRITE : c_READ;
        end
      end
      c_READ: begin
        if (w_fc_done) begin
          w_capture  = 1'b1;
          w_rsp_fire = 1'b1;
          w_next     = c_IDLE;
        end else if (w_tmo_hit) begin
          w_rsp_fire = 1'b1;
          w_rsp_err  = 1'b1;
          w_next     = c_IDLE;
        end
      end
      c_WRITE: begin
        if (w_fc_done) begin
          w_rsp_fire = 1'b1;
          w_next     = c_RELEASE;
        end else if (w_tmo_hit) begin
          w_rsp_fire = 1'b1;
          w_rsp_err  = 1'b1;
          w_next     = c_RELEASE;
        end
      end
      c_RELEASE: begin
        // Hold until the responder drops fc so the next write sees a fresh handshake.
        if (w_fc_done) begin
          if (w_tmo_hit)
            w_next = c_IDLE;
        end else begin
          w_next = c_IDLE;
        end
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_next;
      r_rsp_valid <= w_rsp_fire;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_mask  <= req_mask;
      end
      if (w_rsp_fire)
        r_rsp_rdata <= w_capture ? data_bus : 32'h0;
    end
  end

  assign req_ready     = (r_state == c_IDLE);
  assign rd_bus        = (r_state == c_READ);
  assign wr_bus        = (r_state == c_WRITE);
  assign addr_bus      = r_addr;
  assign data_mask_bus = r_mask;
  assign data_bus      = wr_bus ? r_wdata : 32'bz;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_rdata     = r_rsp_rdata;

endmodule
`default_nettype wire

// File: tb/tb_bus_master_interface.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_bus_master_interface                                          |
// | Brief   : vector table + response scoreboard against a one-register        |
// |           responder at 0x0000_1xxx; BUS_MASTER_TIMEOUT_EN aware.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bus_master_interface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_mask = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] addr_bus;
  wire  [31:0] data_bus;
  logic        rd_bus;
  logic        wr_bus;
  logic [3:0]  data_mask_bus;
  logic        fc_bus;

  always #5 clk = ~clk;

  bus_master_interface #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .addr_bus(addr_bus), .data_bus(data_bus), .rd_bus(rd_bus), .wr_bus(wr_bus),
    .data_mask_bus(data_mask_bus), .fc_bus(fc_bus)
  );

  // Responder: combinational read completion, one-cycle fc pulse after a write.
  logic [31:0] led_reg = 32'h0;
  logic        wr_fc_r;
  logic        sel;
  assign sel      = (addr_bus[31:12] == 20'h00001);
  assign fc_bus   = (rd_bus & sel) | wr_fc_r;
  assign data_bus = (rd_bus & sel) ? led_reg : 32'bz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_fc_r <= 1'b0;
    else        wr_fc_r <= wr_bus & sel & ~wr_fc_r;
  end

  always_ff @(posedge clk) begin
    if (wr_bus && sel && !wr_fc_r)
      for (int b = 0; b < 4; b++)
        if (data_mask_bus[b]) led_reg[b*8 +: 8] <= data_bus[b*8 +: 8];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          c0;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rsp_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("rsp_without_req", 32'(rsp_valid), 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_latency", 32'(cyc - e.c0 + 1), 32'(e.lat));
      end
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    logic        hold;
  } vec_t;

  vec_t vt[12];

  // Called at a negedge; returns at the negedge where req_ready is back.
  task automatic run_vec(input vec_t v);
    int   n;
    exp_t e;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("ready_wait_timeout", 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_mask = v.mask;
    @(posedge clk); #1;
    e.rdata = v.wr ? 32'h0 : v.exp_rdata;
    e.err   = 1'b0;
    e.lat   = v.wr ? 3 : 2;
    e.c0    = cyc;
    sbq.push_back(e);
    @(negedge clk);
    if (v.hold) begin
      req_write = 1'b1; req_addr = 32'h00001008; req_wdata = 32'hBAD0BAD0; req_mask = 4'hF;
    end else begin
      req_valid = 1'b0;
    end
    chk("rd_bus_c1", 32'(rd_bus), 32'(!v.wr));
    chk("wr_bus_c1", 32'(wr_bus), 32'(v.wr));
    chk("addr_bus_c1", addr_bus, v.addr);
    chk("mask_bus_c1", 32'(data_mask_bus), 32'(v.mask));
    if (v.wr) chk("data_bus_c1", data_bus, v.wdata);
    n = 1;
    while (req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (v.hold && n == 3) req_valid = 1'b0;
      if (v.wr && n == 2) chk("wr_bus_c2", 32'(wr_bus), 32'h1);
    end
    chk("ready_cycle", 32'(n), v.wr ? 32'd4 : 32'd2);
  endtask

  initial begin
    vec_t v;
    exp_t e;
    int   n;
    vt[0]  = '{1'b1, 32'h00001004, 32'h00000001, 4'hF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h00001004, 32'h0,        4'hF, 32'h00000001, 1'b0};
    vt[2]  = '{1'b1, 32'h00001004, 32'h00000011, 4'hF, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 32'h00001004, 32'h00000022, 4'hF, 32'h0,        1'b0};
    vt[4]  = '{1'b0, 32'h00001004, 32'h0,        4'hF, 32'h00000022, 1'b0};
    vt[5]  = '{1'b1, 32'h00001005, 32'h000000AB, 4'h1, 32'h0,        1'b0};
    vt[6]  = '{1'b0, 32'h00001005, 32'h0,        4'hF, 32'h000000AB, 1'b0};
    vt[7]  = '{1'b1, 32'h00001004, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b1};
    vt[8]  = '{1'b0, 32'h00001004, 32'h0,        4'hF, 32'h000000AB, 1'b0};
    vt[9]  = '{1'b1, 32'h00001004, 32'hDEADBEEF, 4'hC, 32'h0,        1'b0};
    vt[10] = '{1'b0, 32'h00001000, 32'h0,        4'h3, 32'hDEAD00AB, 1'b0};
    vt[11] = '{1'b0, 32'h00001FFC, 32'h0,        4'h8, 32'hDEAD00AB, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rd_bus", 32'(rd_bus), 32'h0);
    chk("rst_wr_bus", 32'(wr_bus), 32'h0);
    chk("rst_addr_bus", addr_bus, 32'h0);
    chk("rst_mask_bus", 32'(data_mask_bus), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_vec(vt[i]);
    chk("addr_hold_idle", addr_bus, 32'h00001FFC);
    repeat (3) @(negedge clk);
    chk("led_reg_final", led_reg, 32'hDEAD00AB);

    // No responder at 0x9000_0000: abort after 16 cycles, or wait forever.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h90000000; req_mask = 4'hF;
    @(posedge clk); #1;
`ifdef BUS_MASTER_TIMEOUT_EN
    e.rdata = 32'h0; e.err = 1'b1; e.lat = 17; e.c0 = cyc;
    sbq.push_back(e);
`endif
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (req_ready !== 1'b1 && n < 40) begin
      if (n == 16) chk("tmo_rd_bus_c16", 32'(rd_bus), 32'h1);
      @(negedge clk);
      n++;
    end
`ifdef BUS_MASTER_TIMEOUT_EN
    chk("tmo_ready_cycle", 32'(n), 32'd17);
`else
    chk("no_tmo_rd_bus_c40", 32'(rd_bus), 32'h1);
    chk("no_tmo_ready_c40", 32'(req_ready), 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
`endif
    repeat (2) @(negedge clk);

    // Async reset in cycle 2 of a write: strobes and data drop at once, no response.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h00001004;
    req_wdata = 32'h5A5A5A5A; req_mask = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_bus", 32'(wr_bus), 32'h0);
    chk("arst_rd_bus", 32'(rd_bus), 32'h0);
    chk("arst_req_ready", 32'(req_ready), 32'h1);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    n_vec++;
    if (data_bus === 32'h5A5A5A5A) begin
      n_bad++;
      $display("FAIL arst_data_bus_release: got %h, required released bus", data_bus);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    chk("sb_drained", 32'(sbq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
